// File: rtl/keypad_button_encoder_pkg.sv
// Shared calculator button definitions: key codes, chord patterns, FSM states.
// Patterns must stay bit-identical to what math_calculator_fsm decodes.
package calc_button_pkg;

   localparam logic [3:0] KEY_ADD   = 4'd10;
   localparam logic [3:0] KEY_SUB   = 4'd11;
   localparam logic [3:0] KEY_MUL   = 4'd12;
   localparam logic [3:0] KEY_DIV   = 4'd13;
   localparam logic [3:0] KEY_EQUAL = 4'd14;
   localparam logic [3:0] KEY_CLEAR = 4'd15;

   localparam logic [9:0] BTN_NONE  = 10'h000;
   localparam logic [9:0] BTN_ZERO  = 10'h001;
   localparam logic [9:0] BTN_NINE  = 10'h200;
   localparam logic [9:0] BTN_ADD   = 10'h201;
   localparam logic [9:0] BTN_SUB   = 10'h202;
   localparam logic [9:0] BTN_MUL   = 10'h204;
   localparam logic [9:0] BTN_DIV   = 10'h208;
   localparam logic [9:0] BTN_EQUAL = 10'h300;
   localparam logic [9:0] BTN_CLEAR = 10'h380;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_GAP
   } state_e;

   function automatic logic [9:0] key_to_button(input logic [3:0] code);
      logic [9:0] b;
      b = BTN_NONE;
      unique case (1'b1)
         (code < KEY_ADD):    b = BTN_ZERO << code;
         (code == KEY_ADD):   b = BTN_ADD;
         (code == KEY_SUB):   b = BTN_SUB;
         (code == KEY_MUL):   b = BTN_MUL;
         (code == KEY_DIV):   b = BTN_DIV;
         (code == KEY_EQUAL): b = BTN_EQUAL;
         default:             b = BTN_CLEAR;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/keypad_button_encoder_if.sv
// Key-event handshake plus the chord outputs seen by the calculator.
// master = keypad/stimulus side, slave = encoder side.
interface keypad_button_encoder_if;

   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic [9:0] button;
   logic       button_active;
   logic       emit_done;

   modport master (
      output key_valid,
      output key_code,
      input  key_ready,
      input  button,
      input  button_active,
      input  emit_done
   );

   modport slave (
      input  key_valid,
      input  key_code,
      output key_ready,
      output button,
      output button_active,
      output emit_done
   );

endinterface

// File: rtl/keypad_button_encoder_fifo.sv
// key_fifo: small synchronous FIFO of 4-bit key codes.
// Extra pointer MSB distinguishes full from empty.
module key_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic [3:0] data_i,
   input  logic       pop_i,
   output logic [3:0] data_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [3:0]  mem_q [DEPTH];
   logic [AW:0] wr_q;
   logic [AW:0] rd_q;
   logic        wr_en;
   logic        rd_en;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign wr_en   = push_i && !full_o;
   assign rd_en   = pop_i && !empty_o;
   assign data_o  = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_q[AW-1:0]] <= data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (wr_en) wr_q <= wr_q + PTR_ONE;
         if (rd_en) rd_q <= rd_q + PTR_ONE;
      end
   end

endmodule

// File: rtl/keypad_button_encoder.sv
// Turns queued key events into held chord patterns followed by a zero gap.
// BTN_FIFO_EN selects a key_fifo queue; otherwise a single holding register.
module keypad_button_encoder #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input logic                    clk,
   input logic                    rst,
   keypad_button_encoder_if.slave bus
);

   import calc_button_pkg::*;

   localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ?
                         HOLD_CYCLES : GAP_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_cfg_err
      $error("keypad_button_encoder: illegal parameters");
   end

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [9:0]    button_q;
   logic          active_q;
   logic          done_q;

   logic          push;
   logic          pop;
   logic          avail;
   logic [3:0]    head;

   assign push = bus.key_valid && bus.key_ready;
   assign pop  = (state_q == ST_IDLE) && avail;

`ifdef BTN_FIFO_EN
   logic full;
   logic empty;

   key_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (bus.key_code),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign bus.key_ready = !full;
   assign avail         = !empty;
`else
   logic [3:0] hold_q;
   logic       hold_vld_q;

   // push needs an empty register and pop a full one, so they never collide
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else if (push) begin
         hold_q     <= bus.key_code;
         hold_vld_q <= 1'b1;
      end else if (pop) begin
         hold_vld_q <= 1'b0;
      end
   end

   assign bus.key_ready = !hold_vld_q;
   assign avail         = hold_vld_q;
   assign head          = hold_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         button_q <= BTN_NONE;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (avail) begin
                  button_q <= key_to_button(head);
                  active_q <= 1'b1;
                  cnt_q    <= HOLD_LD;
                  state_q  <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               if (cnt_q == '0) begin
                  button_q <= BTN_NONE;
                  active_q <= 1'b0;
                  cnt_q    <= GAP_LD;
                  state_q  <= ST_GAP;
                  done_q   <= (GAP_CYCLES == 1);
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            ST_GAP: begin
               // done is raised entering the last gap cycle
               if (cnt_q == '0) begin
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q  <= cnt_q - CNT_ONE;
                  done_q <= (cnt_q == CNT_ONE);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.button        = button_q;
   assign bus.button_active = active_q;
   assign bus.emit_done     = done_q;

endmodule

// File: tb/tb_keypad_button_encoder.sv
// Scoreboard bench for keypad_button_encoder.
// Expected chords are queued on accept and popped when a pattern appears.
module tb_keypad_button_encoder;

   localparam int HOLD = 4;
   localparam int GAP  = 2;
   localparam int DEPTH = 4;

   logic clk;
   logic rst;

   keypad_button_encoder_if bus();

   keypad_button_encoder #(
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [9:0] exp_q[$];
   time        acc_t[$];
   int         emit_exp = 0;

   logic [9:0] prev = '0;
   int         run = 0;
   int         zrun = 0;
   bit         have_prev = 1'b0;
   int         n_pat = 0;
   int         n_emit = 0;
   time        t_start = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [9:0] model(input int c);
      logic [9:0] m;
      m = '0;
      if (c < 10) m[c] = 1'b1;
      else if (c == 10) m = 10'h201;
      else if (c == 11) m = 10'h202;
      else if (c == 12) m = 10'h204;
      else if (c == 13) m = 10'h208;
      else if (c == 14) m = 10'h300;
      else m = 10'h380;
      return m;
   endfunction

   // monitor: pattern identity, hold length, stability, gap, spacing
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev = '0;
         run = 0;
         zrun = 0;
         have_prev = 1'b0;
      end else begin
         if (bus.button != '0) begin
            if (prev == '0) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_pattern", 32'(bus.button), 0);
               end else begin
                  chk("pattern", 32'(bus.button), 32'(exp_q.pop_front()));
               end
               chk("active_on", 32'(bus.button_active), 1);
               if (have_prev) chk("spacing", zrun, GAP + 1);
               have_prev = 1'b1;
               run = 1;
               n_pat++;
               t_start = $time;
            end else begin
               chk("stable", 32'(bus.button), 32'(prev));
               run++;
            end
         end else begin
            if (prev != '0) begin
               chk("hold", run, HOLD);
               chk("active_off", 32'(bus.button_active), 0);
               zrun = 0;
            end
            zrun++;
         end
         if (bus.emit_done) begin
            chk("emit_btn", 32'(bus.button), 0);
            chk("emit_gap", zrun, GAP);
            n_emit++;
         end
         prev = bus.button;
      end
   end

   // called just after a posedge; returns just after the accepting posedge
   task automatic send_key(input int c, output time t_acc);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      t_acc = 0;
      bus.key_valid = 1'b1;
      bus.key_code = 4'(c);
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = bus.key_ready;
         @(posedge clk);
         t_acc = $time;
         #1;
         n++;
      end
      if (acc) begin
         exp_q.push_back(model(c));
         acc_t.push_back(t_acc);
         emit_exp++;
      end else begin
         chk("accept_timeout", 0, 1);
      end
   endtask

   task automatic idle_in();
      bus.key_valid = 1'b0;
      bus.key_code = 4'(0);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((n_emit < emit_exp || exp_q.size() != 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_emits", n_emit, emit_exp);
      chk("drain_queue", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      time t;
      time t0;
      int  emits_before;
      int  pats_before;

      rst = 1'b1;
      idle_in();

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_button", 32'(bus.button), 0);
      chk("rst_active", 32'(bus.button_active), 0);
      chk("rst_emit", 32'(bus.emit_done), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(bus.key_ready), 1);
      @(posedge clk);
      #1;

      // package table against the bench model
      for (int c = 0; c < 16; c++) begin
         chk("pkg_table", 32'(calc_button_pkg::key_to_button(4'(c))),
             32'(model(c)));
      end

      // single key 7
      have_prev = 1'b0;
      acc_t.delete();
      send_key(7, t);
      idle_in();
      wait_drain();
      chk("latency", 32'(t_start - t), 15);
      chk("emit_count", n_emit, 1);

      // all 16 codes, offered every cycle
      have_prev = 1'b0;
      acc_t.delete();
      for (int c = 0; c < 16; c++) send_key(c, t);
      idle_in();
      wait_drain();
`ifndef BTN_FIFO_EN
      chk("acc_first", 32'((acc_t[1] - acc_t[0]) / 10), 2);
      for (int i = 2; i < 16; i++) begin
         chk("acc_space", 32'((acc_t[i] - acc_t[i-1]) / 10), HOLD + GAP + 1);
      end
`else
      // burst of four with no stall
      have_prev = 1'b0;
      acc_t.delete();
      send_key(1, t);
      send_key(10, t);
      send_key(2, t);
      send_key(14, t);
      idle_in();
      for (int i = 1; i < 4; i++) begin
         chk("burst_space", 32'((acc_t[i] - acc_t[i-1]) / 10), 1);
      end
      wait_drain();

      // overfill: six keys continuously
      have_prev = 1'b0;
      acc_t.delete();
      for (int c = 3; c < 8; c++) send_key(c, t);
      @(negedge clk);
      chk("full_ready", 32'(bus.key_ready), 0);
      send_key(8, t);
      idle_in();
      for (int i = 1; i < 5; i++) begin
         chk("fill_space", 32'((acc_t[i] - acc_t[i-1]) / 10), 1);
      end
      chk("refill_time", 32'((acc_t[5] - acc_t[0]) / 10), 9);
      wait_drain();
`endif

      // reset during DRIVE of MUL with keys pending
      have_prev = 1'b0;
      acc_t.delete();
      send_key(12, t0);
      send_key(3, t);
`ifdef BTN_FIFO_EN
      send_key(4, t);
`endif
      idle_in();
      rst = 1'b1;
      emits_before = n_emit;
      pats_before = n_pat;
      @(negedge clk);
      chk("pre_rst_button", 32'(bus.button), 32'(10'h204));
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_button", 32'(bus.button), 0);
      chk("mid_rst_active", 32'(bus.button_active), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(bus.key_ready), 1);
      repeat (20) @(negedge clk);
      chk("post_rst_emit", n_emit, emits_before);
      chk("post_rst_pat", n_pat, pats_before);
      emit_exp = n_emit;
      @(posedge clk);
      #1;

      // recovery with CLEAR
      have_prev = 1'b0;
      send_key(15, t);
      idle_in();
      wait_drain();
      chk("final_button", 32'(bus.button), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
